// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter
//   Arbitrates two masters, M0 (CPU load/store) and M1 (JTAG debug port),
//   onto a three-slave bus (RAM, timer, UART). Only one transfer is in
//   flight at a time. Each transfer ends in one of three ways: the selected
//   slave's ready, an unmapped address, or a timeout.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   m{0,1}_req_i/we_i        master request / write flag
//   m{0,1}_addr_i/wdata_i    master byte address / write data
//   m{0,1}_gnt_o             one-cycle pulse: command accepted
//   m{0,1}_rvalid_o          one-cycle pulse: transfer complete
//   m{0,1}_rdata_o/err_o     read data / error; held until the next completion
//   s_sel_o                  one-hot slave select (bit0 RAM, bit1 timer, bit2 UART)
//   s_we_o/addr_o/wdata_o    latched command towards the slaves
//   s{0,1,2}_rdata_i         per-slave read data
//   s_ready_i                per-slave completion
//   busy_o                   transfer in progress (BUSY or RESP)
//
// state | meaning
// IDLE  | arbitrate; latch the winner's command
// BUSY  | command on the bus, waiting for ready, unmapped decode or timeout
// RESP  | rvalid to the owner for one cycle
module soc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        m0_err_o,
  output logic        m1_err_o,
  output logic [2:0]  s_sel_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s0_rdata_i,
  input  logic [31:0] s1_rdata_i,
  input  logic [31:0] s2_rdata_i,
  input  logic [2:0]  s_ready_i,
  output logic        busy_o
);

  localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [SW-1:0] LP_STARVE  = SW'(STARVE_LIMIT);
  localparam logic [7:0]    LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner;        // 0 = M0, 1 = M1
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_gnt0, r_gnt1;
  logic [SW-1:0] r_starve;
  logic [7:0]    r_to_cnt;
  logic [31:0]   r_m0_rdata, r_m1_rdata;
  logic          r_m0_err, r_m1_err;

  logic          w_any_req, w_grant_m0, w_grant_m1;
  logic [2:0]    w_dec;
  logic          w_ready_sel, w_unmapped, w_timeout, w_done;
  logic [31:0]   w_rdata_sel, w_rdata_cap;

  // M1 has priority unless M0 has been passed over STARVE_LIMIT times in a row.
  assign w_any_req  = m0_req_i | m1_req_i;
  assign w_grant_m0 = m0_req_i & (~m1_req_i | (r_starve == LP_STARVE));
  assign w_grant_m1 = m1_req_i & ~w_grant_m0;

  always_comb begin
    w_dec = 3'b000;
    case (r_addr[31:28])
      4'h0:    w_dec = 3'b001;
      4'h1:    w_dec = 3'b010;
      4'h2:    w_dec = 3'b100;
      default: w_dec = 3'b000;
    endcase
  end

  always_comb begin
    w_rdata_sel = 32'd0;
    case (w_dec)
      3'b001:  w_rdata_sel = s0_rdata_i;
      3'b010:  w_rdata_sel = s1_rdata_i;
      3'b100:  w_rdata_sel = s2_rdata_i;
      default: w_rdata_sel = 32'd0;
    endcase
  end

  // Ready from unselected slaves is masked off; ready beats timeout.
  assign w_ready_sel = |(w_dec & s_ready_i);
  assign w_unmapped  = (w_dec == 3'b000);
  assign w_timeout   = (r_to_cnt == LP_TO_LAST);
  assign w_done      = w_ready_sel | w_unmapped | w_timeout;
  assign w_rdata_cap = w_ready_sel ? w_rdata_sel : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = BUSY;
      BUSY:    if (w_done)    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_starve   <= '0;
      r_to_cnt   <= 8'd0;
      r_m0_rdata <= 32'd0;
      r_m1_rdata <= 32'd0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      if (r_state == IDLE && w_any_req) begin
        r_owner  <= w_grant_m1;
        r_we     <= w_grant_m1 ? m1_we_i    : m0_we_i;
        r_addr   <= w_grant_m1 ? m1_addr_i  : m0_addr_i;
        r_wdata  <= w_grant_m1 ? m1_wdata_i : m0_wdata_i;
        r_gnt0   <= w_grant_m0;
        r_gnt1   <= w_grant_m1;
        r_to_cnt <= 8'd0;
        if (w_grant_m0 || !m0_req_i)  r_starve <= '0;
        else if (r_starve != LP_STARVE) r_starve <= r_starve + 1'b1;
      end
      if (r_state == BUSY) begin
        if (!w_done) begin
          r_to_cnt <= r_to_cnt + 8'd1;
        end else if (r_owner) begin
          r_m1_rdata <= w_rdata_cap;
          r_m1_err   <= ~w_ready_sel;
        end else begin
          r_m0_rdata <= w_rdata_cap;
          r_m0_err   <= ~w_ready_sel;
        end
      end
    end
  end

  assign m0_gnt_o    = r_gnt0;
  assign m1_gnt_o    = r_gnt1;
  assign m0_rvalid_o = (r_state == RESP) & ~r_owner;
  assign m1_rvalid_o = (r_state == RESP) &  r_owner;
  assign m0_rdata_o  = r_m0_rdata;
  assign m1_rdata_o  = r_m1_rdata;
  assign m0_err_o    = r_m0_err;
  assign m1_err_o    = r_m1_err;
  assign s_sel_o     = (r_state == BUSY) ? w_dec : 3'b000;
  assign s_we_o      = (r_state == BUSY) & r_we;
  assign s_addr_o    = r_addr;
  assign s_wdata_o   = r_wdata;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_soc_bus_arbiter.sv
module tb_soc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic [2:0]  s_sel_o;
  logic        s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [31:0] s0_rdata_i, s1_rdata_i, s2_rdata_i;
  logic [2:0]  s_ready_i;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_bus_arbiter #(.TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
    .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s0_rdata_i(s0_rdata_i), .s1_rdata_i(s1_rdata_i), .s2_rdata_i(s2_rdata_i),
    .s_ready_i(s_ready_i), .busy_o(busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int g = 0;
    while (busy_o && g < 40) begin
      tick();
      g++;
    end
    check_eq("drain_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int gcount;
    int guard;
    logic [5:0] order;
    logic seen;

    rst = 1'b0;
    m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_addr_i = 0; m1_addr_i = 0; m0_wdata_i = 0; m1_wdata_i = 0;
    s0_rdata_i = 0; s1_rdata_i = 0; s2_rdata_i = 0; s_ready_i = 0;
    tick(); tick();

    // Reset state
    check_eq("rst_busy",   32'(busy_o), 32'd0);
    check_eq("rst_gnt",    32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    check_eq("rst_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
    check_eq("rst_sel",    32'(s_sel_o), 32'd0);
    check_eq("rst_m0_rdata", m0_rdata_o, 32'd0);

    // M0 read RAM, ready in first BUSY cycle; request at the first edge after reset
    rst = 1'b1;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h0000_0010;
    s0_rdata_i = 32'hDEAD_BEEF; s_ready_i = 3'b001;
    tick();
    check_eq("rd_m0_gnt",  32'(m0_gnt_o), 32'd1);
    check_eq("rd_m1_gnt",  32'(m1_gnt_o), 32'd0);
    check_eq("rd_busy",    32'(busy_o), 32'd1);
    check_eq("rd_sel",     32'(s_sel_o), 32'd1);
    check_eq("rd_addr",    s_addr_o, 32'h0000_0010);
    check_eq("rd_we",      32'(s_we_o), 32'd0);
    m0_req_i = 0;
    tick();
    check_eq("rd_rvalid",  32'(m0_rvalid_o), 32'd1);
    check_eq("rd_rdata",   m0_rdata_o, 32'hDEAD_BEEF);
    check_eq("rd_err",     32'(m0_err_o), 32'd0);
    check_eq("rd_gnt_off", 32'(m0_gnt_o), 32'd0);
    tick();
    check_eq("rd_rvalid_off", 32'(m0_rvalid_o), 32'd0);
    check_eq("rd_idle",       32'(busy_o), 32'd0);
    check_eq("rd_hold",       m0_rdata_o, 32'hDEAD_BEEF);
    s_ready_i = 3'b000;

    // Timer read; ready from RAM and UART must be ignored
    m0_req_i = 1; m0_addr_i = 32'h1000_0004;
    s1_rdata_i = 32'h1234_5678; s_ready_i = 3'b101;
    tick();
    check_eq("tmr_gnt", 32'(m0_gnt_o), 32'd1);
    check_eq("tmr_sel", 32'(s_sel_o), 32'd2);
    m0_req_i = 0;
    tick();
    check_eq("tmr_ignore_rvalid", 32'(m0_rvalid_o), 32'd0);
    check_eq("tmr_still_busy",    32'(busy_o), 32'd1);
    check_eq("tmr_sel_stable",    32'(s_sel_o), 32'd2);
    s_ready_i = 3'b010;
    tick();
    check_eq("tmr_rvalid", 32'(m0_rvalid_o), 32'd1);
    check_eq("tmr_rdata",  m0_rdata_o, 32'h1234_5678);
    s_ready_i = 3'b000;
    tick();

    // M1 write to unmapped address
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h3000_0000; m1_wdata_i = 32'hA5A5_0001;
    s_ready_i = 3'b111;
    tick();
    check_eq("unm_gnt",   32'(m1_gnt_o), 32'd1);
    check_eq("unm_sel",   32'(s_sel_o), 32'd0);
    check_eq("unm_we",    32'(s_we_o), 32'd1);
    check_eq("unm_wdata", s_wdata_o, 32'hA5A5_0001);
    m1_req_i = 0;
    tick();
    check_eq("unm_rvalid",  32'(m1_rvalid_o), 32'd1);
    check_eq("unm_err",     32'(m1_err_o), 32'd1);
    check_eq("unm_rdata",   m1_rdata_o, 32'd0);
    check_eq("unm_m0_hold", m0_rdata_o, 32'h1234_5678);
    s_ready_i = 3'b000;
    tick();

    // Timer never ready: timeout after 16 BUSY cycles
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h1000_0000;
    s1_rdata_i = 32'hCAFE_F00D;
    tick();
    check_eq("to_gnt", 32'(m0_gnt_o), 32'd1);
    m0_req_i = 0;
    k = 1;
    while (!m0_rvalid_o && k < 40) begin
      tick();
      k++;
    end
    check_eq("to_busy_cycles", 32'(k - 1), 32'd16);
    check_eq("to_err",   32'(m0_err_o), 32'd1);
    check_eq("to_rdata", m0_rdata_o, 32'd0);
    tick();

    // Ready on the 16th BUSY cycle wins over timeout
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h1000_0008;
    s1_rdata_i = 32'h0F0F_1234;
    tick();
    check_eq("tor_gnt", 32'(m1_gnt_o), 32'd1);
    m1_req_i = 0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("tor_no_early_rvalid", 32'(m1_rvalid_o), 32'd0);
    s_ready_i = 3'b010;
    tick();
    check_eq("tor_rvalid", 32'(m1_rvalid_o), 32'd1);
    check_eq("tor_err",    32'(m1_err_o), 32'd0);
    check_eq("tor_rdata",  m1_rdata_o, 32'h0F0F_1234);
    s_ready_i = 3'b000;
    tick();

    // Starvation: both masters requesting continuously
    m0_req_i = 1; m0_addr_i = 32'h0000_0100;
    m1_req_i = 1; m1_addr_i = 32'h0000_0200;
    s_ready_i = 3'b001;
    gcount = 0; guard = 0; order = '0;
    while (gcount < 6 && guard < 60) begin
      tick();
      guard++;
      if (m0_gnt_o) begin
        order[gcount] = 1'b0;
        gcount++;
      end else if (m1_gnt_o) begin
        order[gcount] = 1'b1;
        gcount++;
      end
    end
    m0_req_i = 0; m1_req_i = 0;
    check_eq("starve_ngrants", 32'(gcount), 32'd6);
    check_eq("starve_order",   32'(order), 32'(6'b101111));
    drain();
    s_ready_i = 3'b000;

    // Request raised while busy is not granted; withdrawn before IDLE it is cancelled
    m1_req_i = 1; m1_addr_i = 32'h2000_0000; s2_rdata_i = 32'h5555_AAAA;
    tick();
    check_eq("cx_m1_gnt", 32'(m1_gnt_o), 32'd1);
    m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h0000_0000;
    tick();
    check_eq("cx_m0_no_gnt_busy", 32'(m0_gnt_o), 32'd0);
    s_ready_i = 3'b100;
    tick();
    check_eq("cx_m1_rvalid", 32'(m1_rvalid_o), 32'd1);
    m0_req_i = 0; s_ready_i = 3'b000;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | m0_gnt_o;
    end
    check_eq("cx_cancelled", 32'(seen), 32'd0);
    check_eq("cx_idle",      32'(busy_o), 32'd0);

    // Reset during BUSY
    m0_req_i = 1; m0_addr_i = 32'h0000_0040;
    tick();
    check_eq("rb_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rb_busy",     32'(busy_o), 32'd0);
    check_eq("rb_sel",      32'(s_sel_o), 32'd0);
    check_eq("rb_addr",     s_addr_o, 32'd0);
    check_eq("rb_gnt",      32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    check_eq("rb_m1_rdata", m1_rdata_o, 32'd0);
    m0_req_i = 0; s_ready_i = 3'b001;
    tick(); tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | m0_rvalid_o | m1_rvalid_o;
    end
    check_eq("rb_no_rvalid", 32'(seen), 32'd0);
    s_ready_i = 3'b000;
    m1_req_i = 1; m1_addr_i = 32'h2000_0010; s2_rdata_i = 32'h0BAD_F00D;
    s_ready_i = 3'b100;
    tick();
    check_eq("rb_next_gnt", 32'(m1_gnt_o), 32'd1);
    check_eq("rb_next_sel", 32'(s_sel_o), 32'd4);
    m1_req_i = 0;
    tick();
    check_eq("rb_next_rvalid", 32'(m1_rvalid_o), 32'd1);
    check_eq("rb_next_rdata",  m1_rdata_o, 32'h0BAD_F00D);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a slave may hold a transfer before it is aborted (legal range 2..255).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive M1 grants allowed while an M0 request is pending.
REQ-003 SHALL have ports:
 clk  in  1  single clock, rising edge.
 rst  in  1  asynchronous, active-low reset.
 m0_req_i, m1_req_i  in  1  request; M0 = CPU load/store, M1 = JTAG debug memory port.
 m0_we_i, m1_we_i  in  1  1 = write.
 m0_addr_i, m1_addr_i  in  32  byte address.
 m0_wdata_i, m1_wdata_i  in  32  write data.
 m0_gnt_o, m1_gnt_o  out  1  one-cycle pulse: command accepted.
 m0_rvalid_o, m1_rvalid_o  out  1  one-cycle pulse: transfer complete.
 m0_rdata_o, m1_rdata_o  out  32  read data, valid with rvalid.
 m0_err_o, m1_err_o  out  1  error, valid with rvalid.
 s_sel_o  out  3  one-hot slave select: bit0 RAM, bit1 timer, bit2 UART.
 s_we_o  out  1  write strobe.
 s_addr_o  out  32  address.
 s_wdata_o  out  32  write data.
 s0_rdata_i, s1_rdata_i, s2_rdata_i  in  32  per-slave read data.
 s_ready_i  in  3  per-slave completion, one bit per slave.
 busy_o  out  1  FSM not in IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-005 In IDLE with any request pending, SHALL register the winner's we, addr and wdata, pulse that master's gnt_o in the next cycle, and enter BUSY in that same next cycle.
REQ-006 Arbitration SHALL be fixed priority M1 over M0, except that M0 wins when m0_req_i=1 and starve_cnt equals STARVE_LIMIT.
REQ-007 starve_cnt (3-bit minimum) SHALL increment on each M1 grant made while m0_req_i=1, clear on any M0 grant, clear on an M1 grant made with m0_req_i=0, and saturate at STARVE_LIMIT.
REQ-008 Decode SHALL use addr[31:28]: 0x0 selects RAM, 0x1 selects timer, 0x2 selects UART; every other value is unmapped.
REQ-009 In BUSY, s_sel_o SHALL carry the decoded one-hot value and s_we_o/s_addr_o/s_wdata_o the latched command; these SHALL be held stable until the cycle after completion.
REQ-010 BUSY SHALL complete when the selected slave's s_ready_i bit is 1; in that cycle rdata SHALL be captured from the selected slave and err cleared, and the FSM SHALL enter RESP.
REQ-011 s_ready_i bits of unselected slaves SHALL be ignored.
REQ-012 An unmapped address SHALL drive s_sel_o=0 and complete after exactly 1 BUSY cycle with err=1 and rdata=0.
REQ-013 A timeout counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-014 When the timeout counter reaches TIMEOUT_CYCLES-1 with no ready, the transfer SHALL complete with err=1 and rdata=0.
REQ-015 Ready arriving in the same cycle as timeout SHALL win: transfer completes normally with err=0.
REQ-016 In RESP, the owner's rvalid_o SHALL be 1 for exactly one cycle with rdata_o and err_o valid; the FSM SHALL then return to IDLE.
REQ-017 m*_rdata_o and m*_err_o SHALL hold their last values outside RESP.
REQ-018 Arbitration SHALL resume in IDLE the cycle after RESP, giving 3 cycles minimum per transfer (req -> gnt +1, ready at +1, rvalid at +2).
REQ-019 Writes SHALL also produce rvalid; rdata SHALL be don't-care for writes but must not be X.
REQ-020 Requests arriving during BUSY or RESP SHALL not be granted until IDLE; masters hold req and payload until gnt.
REQ-021 Deasserting req before gnt SHALL be legal and SHALL cancel that request with no gnt; the registered grant decision SHALL use req as sampled in IDLE.
REQ-022 busy_o SHALL be 1 in BUSY and RESP.

Reset
REQ-023 On rst=0 the block SHALL asynchronously enter IDLE and zero all outputs, rdata and err registers, starve_cnt and the timeout counter.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no rvalid afterwards.
REQ-025 After rst deasserts, the first grant SHALL be possible on the first clock edge.

Verification
REQ-026 M0 read 0x0000_0010, RAM ready at first BUSY cycle with data 0xDEADBEEF -> m0_gnt at cycle 1, m0_rvalid at cycle 2, rdata 0xDEADBEEF, err 0.
REQ-027 M0 and M1 requesting continuously -> grant order M1,M1,M1,M1,M0,M1,... with STARVE_LIMIT=4.
REQ-028 M1 write 0x3000_0000 -> s_sel_o=0, m1_rvalid after 1 BUSY cycle, err=1, rdata 0.
REQ-029 Timer never asserts ready, TIMEOUT_CYCLES=16 -> rvalid with err=1 after 16 BUSY cycles; ready injected on the 16th BUSY cycle -> err=0.
REQ-030 rst pulled low during BUSY -> all outputs 0 immediately, no rvalid afterwards, next request granted normally.
